// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and sizing for the pipeline run/hazard controller
package pipe_pkg;
  localparam int NREG = 16;
  localparam int RIDX_W = 4;
  localparam int LAT = 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic v;
    logic [RIDX_W-1:0] rd;
  } sb_entry_t;
endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: shift line of in-flight register writes with RAW hit decode
module pipe_scoreboard
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_v,
  input  logic [RIDX_W-1:0] push_rd,
  input  logic [RIDX_W-1:0] rs,
  input  logic [RIDX_W-1:0] rt,
  output logic              hit_rs,
  output logic              hit_rt,
  output logic              empty
);
  sb_entry_t [LAT-1:0] line;
  sb_entry_t head;
  logic [NREG-1:0] pending;
  assign head = '{v: push && push_v, rd: push ? push_rd : '0};
  // Advance one slot per clock; edges without an issue insert an invalid slot
  always_ff @(posedge clk or posedge rst)
    if (rst) line <= '0;
    else line <= {line[LAT-2:0], head};
  // Decode in-flight destinations into a per-register pending mask
  always_comb begin
    pending = '0;
    for (int i = 0; i < LAT; i++) if (line[i].v) pending[line[i].rd] = 1'b1;
  end
  // The last slot retires on the coming edge, so only earlier slots keep the line busy
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < LAT - 1; i++) if (line[i].v) empty = 1'b0;
  end
  assign hit_rs = rs != '0 && pending[rs];
  assign hit_rt = rt != '0 && pending[rt];
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: idle/run/drain sequencing and RAW stall control; PIPE_CTRL_STALL_CNT_EN adds a stall counter
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              id_valid,
  input  logic [RIDX_W-1:0] id_rs,
  input  logic [RIDX_W-1:0] id_rt,
  input  logic [RIDX_W-1:0] id_rd,
  input  logic              id_wr,
  output logic              pc_en,
  output logic              id_en,
  output logic              ex_bubble,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt
);
  state_t state, state_nx;
  logic hit_rs, hit_rt, empty, hazard, run_ok, issue;
  assign hazard = id_valid && (hit_rs || hit_rt);
  assign run_ok = state == RUN && !hazard;
  assign issue = run_ok && id_valid;
  pipe_scoreboard u_sb (
    .clk(clk),
    .rst(rst),
    .push(issue),
    .push_v(id_wr && id_rd != '0),
    .push_rd(id_rd),
    .rs(id_rs),
    .rt(id_rt),
    .hit_rs(hit_rs),
    .hit_rt(hit_rt),
    .empty(empty)
  );
  // State register plus the one-cycle done pulse on leaving DRAIN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= state == DRAIN && state_nx == IDLE;
    end
  // Next state and pipeline enables; only a hazard-free RUN cycle lets the pipe advance
  always_comb begin
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (halt_req ? DRAIN : RUN) :
               (empty ? IDLE : DRAIN);
    pc_en = run_ok;
    id_en = run_ok;
    ex_bubble = !run_ok || !id_valid;
    busy = state != IDLE;
  end
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [15:0] cnt;
  // Saturating count of hazard cycles in RUN, restarted on each IDLE->RUN
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (state == IDLE && start) cnt <= '0;
    else if (state == RUN && hazard && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  assign stall_cnt = cnt;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus random traffic against a register-ready-time model
module tb_pipe_ctrl;
  import pipe_pkg::*;
  logic clk = 0, rst = 1, start = 0, halt_req = 0, id_valid = 0, id_wr = 0;
  logic [RIDX_W-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic pc_en, id_en, ex_bubble, busy, done;
  logic [15:0] stall_cnt;
  int tests = 0, fails = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_wr(id_wr),
    .pc_en(pc_en), .id_en(id_en), .ex_bubble(ex_bubble), .busy(busy), .done(done),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: per register, the last cycle in which a reader must still stall
  int cyc = 0, ms = 0, cnt = 0;
  int bu[NREG];
  bit dexp = 0;
  always @(negedge clk) begin
    bit haz, ok, clr;
    if (rst) begin
      ms = 0; cnt = 0; dexp = 0;
      foreach (bu[i]) bu[i] = -100;
      check("rst_pc_en", pc_en, 0);
      check("rst_id_en", id_en, 0);
      check("rst_ex_bubble", ex_bubble, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_stall_cnt", stall_cnt, 0);
    end else begin
      haz = id_valid && ((id_rs != 0 && bu[id_rs] >= cyc) || (id_rt != 0 && bu[id_rt] >= cyc));
      ok = ms == 1 && !haz;
      check("pc_en", pc_en, ok);
      check("id_en", id_en, ok);
      check("ex_bubble", ex_bubble, !ok || !id_valid);
      check("busy", busy, ms != 0);
      check("done", done, dexp);
`ifdef PIPE_CTRL_STALL_CNT_EN
      check("stall_cnt", stall_cnt, cnt);
`else
      check("stall_cnt", stall_cnt, 0);
`endif
      clr = 1;
      foreach (bu[i]) if (bu[i] > cyc) clr = 0;
      if (ok && id_valid && id_wr && id_rd != 0) bu[id_rd] = cyc + LAT;
      if (ms == 0 && start) cnt = 0;
      else if (ms == 1 && haz && cnt < 65535) cnt++;
      dexp = ms == 2 && clr;
      ms = ms == 0 ? (start ? 1 : 0) : ms == 1 ? (halt_req ? 2 : 1) : (clr ? 0 : 2);
    end
    cyc++;
  end

  task automatic idle(input int n);
    id_valid = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                      input logic wr, output int stalls);
    bit ok;
    ok = 0; stalls = 0;
    id_valid = 1; id_rs = rs; id_rt = rt; id_rd = rd; id_wr = wr;
    for (int i = 0; i < 16 && !ok; i++) begin
      @(negedge clk);
      if (id_en) ok = 1; else stalls++;
    end
    if (!ok) check("send_timeout", 0, 1);
    @(posedge clk); #1 id_valid = 0;
  endtask

  initial begin
    int s, n, dn;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    start = 1; id_valid = 1; id_rs = 0; id_rt = 0; id_rd = 0; id_wr = 0;
    @(posedge clk); #1 start = 0;
    check("busy_after_start", busy, 1);
    n = 0;
    repeat (3) begin @(negedge clk); if (pc_en && id_en) n++; end
    check("run_en_cycles", n, 3);
    @(posedge clk); #1;
    idle(3);
    send(1, 2, 3, 1, s); check("b2b_producer_stalls", s, 0);
    send(3, 1, 4, 1, s); check("b2b_consumer_stalls", s, 2);
`ifdef PIPE_CTRL_STALL_CNT_EN
    check("stall_cnt_b2b", stall_cnt, 2);
`endif
    idle(3);
    send(1, 1, 0, 1, s); send(0, 0, 6, 1, s); check("r0_stalls", s, 0);
    idle(3);
    send(7, 7, 5, 1, s); send(1, 2, 8, 1, s); send(5, 0, 9, 1, s); check("gap1_stalls", s, 1);
    idle(3);
    send(9, 9, 5, 1, s); send(1, 2, 8, 1, s); send(2, 1, 10, 1, s); send(0, 5, 11, 1, s);
    check("gap2_stalls", s, 0);
    idle(3);
    send(0, 0, 12, 1, s);
    id_valid = 1; id_rs = 0; id_rt = 0; id_rd = 13; id_wr = 1; halt_req = 1;
    @(negedge clk); check("halt_issue", id_en, 1);
    @(posedge clk); #1 halt_req = 0; id_valid = 0;
    n = 0; dn = 0;
    repeat (6) begin @(negedge clk); if (busy) n++; if (done) dn++; end
    check("drain_cycles", n, 2);
    check("drain_done_pulses", dn, 1);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    idle(3);
    halt_req = 1;
    @(posedge clk); #1 halt_req = 0;
    n = 0;
    repeat (4) begin @(negedge clk); if (busy) n++; end
    check("drain_empty_cycles", n, 1);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    send(0, 0, 12, 1, s);
    id_valid = 1; id_rs = 12; id_rt = 0; id_rd = 1; id_wr = 1;
    @(negedge clk); check("stall_before_rst", pc_en, 0);
    @(posedge clk); #1 rst = 1;
    #1 check("rst_mid_busy", busy, 0); check("rst_mid_pc_en", pc_en, 0);
    @(posedge clk); #1 rst = 0; id_valid = 0;
    dn = 0;
    repeat (4) begin @(negedge clk); if (done) dn++; end
    check("rst_no_done", dn, 0);
    check("rst_stall_cnt_zero", stall_cnt, 0);
    repeat (3000) begin
      @(posedge clk); #1;
      rst = $urandom_range(0, 299) == 0;
      start = $urandom_range(0, 9) == 0;
      halt_req = $urandom_range(0, 29) == 0;
      id_valid = $urandom_range(0, 3) != 0;
      id_rs = 4'($urandom_range(0, 4));
      id_rt = 4'($urandom_range(0, 4));
      id_rd = 4'($urandom_range(0, 4));
      id_wr = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 rst = 0; start = 0; halt_req = 0; id_valid = 0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
